// File: rtl/aircon_mode_ctrl.sv
// Mode sequencer for the aircon bargraph display: turns three push buttons into
// a legal one-hot Thermo code plus a cool-only, time-limited Turbo request.
module aircon_mode_ctrl #(
  parameter int COMP_DELAY = 16,
  parameter int TURBO_TIME = 64,
  parameter int CNT_W      = 8
) (
  input  logic       Clk_In,
  input  logic       Reset_In,
  input  logic       Power_Btn_In,
  input  logic       Mode_Btn_In,
  input  logic       Turbo_Btn_In,
  output logic [3:0] Thermo_Out,
  output logic       Turbo_Out,
  output logic       Busy_Out,
  output logic       Err_Out
);

  typedef enum logic [2:0] {
    ST_OFF,
    ST_LOW_FAN,
    ST_HIGH_FAN,
    ST_COOL_WAIT,
    ST_LOW_COOL,
    ST_HIGH_COOL
  } state_t;

  localparam logic [CNT_W-1:0] COMP_LOAD  = CNT_W'(COMP_DELAY - 1);
  localparam logic [CNT_W-1:0] TURBO_LOAD = CNT_W'(TURBO_TIME - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             turbo_q, turbo_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;
  logic [3:0]       thermo_q, thermo_d;
  logic             pwr_prev_q, mode_prev_q, turbo_prev_q;
  logic             pwr_press, mode_press, turbo_press;
  logic             in_cool;

  assign pwr_press   = Power_Btn_In & ~pwr_prev_q;
  assign mode_press  = Mode_Btn_In  & ~mode_prev_q;
  assign turbo_press = Turbo_Btn_In & ~turbo_prev_q;
  assign in_cool     = (state_q == ST_LOW_COOL) || (state_q == ST_HIGH_COOL);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    turbo_d = turbo_q;
    err_d   = 1'b0;

    // The counter serves the hold-off in COOL_WAIT and the turbo timer in the
    // cool states; the two uses never overlap.
    if (state_q == ST_COOL_WAIT) begin
      if (cnt_q == '0) state_d = ST_LOW_COOL;
      else             cnt_d   = cnt_q - CNT_ONE;
    end else if (turbo_q) begin
      if (cnt_q == '0) turbo_d = 1'b0;
      else             cnt_d   = cnt_q - CNT_ONE;
    end

    if (pwr_press) begin
      if (state_q == ST_OFF) begin
        state_d = ST_LOW_FAN;
      end else begin
        state_d = ST_OFF;
        turbo_d = 1'b0;
        cnt_d   = '0;
      end
    end else if (mode_press) begin
      case (state_q)
        ST_LOW_FAN:  state_d = ST_HIGH_FAN;
        ST_HIGH_FAN: begin
          state_d = ST_COOL_WAIT;
          cnt_d   = COMP_LOAD;
        end
        ST_LOW_COOL: state_d = ST_HIGH_COOL;
        ST_HIGH_COOL: begin
          state_d = ST_LOW_FAN;
          turbo_d = 1'b0;
          cnt_d   = '0;
        end
        default:     err_d = 1'b1;
      endcase
    end else if (turbo_press) begin
      if (!in_cool) begin
        err_d = 1'b1;
      end else if (turbo_q) begin
        // A press coinciding with expiry lands here too, so both agree on off.
        turbo_d = 1'b0;
        cnt_d   = '0;
      end else begin
        turbo_d = 1'b1;
        cnt_d   = TURBO_LOAD;
      end
    end

    case (state_d)
      ST_LOW_FAN:   thermo_d = 4'b0001;
      ST_HIGH_FAN:  thermo_d = 4'b0010;
      ST_COOL_WAIT: thermo_d = 4'b0010;
      ST_LOW_COOL:  thermo_d = 4'b0100;
      ST_HIGH_COOL: thermo_d = 4'b1000;
      default:      thermo_d = 4'b0000;
    endcase
    busy_d = (state_d == ST_COOL_WAIT);
  end

  always_ff @(posedge Clk_In) begin
    if (Reset_In) begin
      state_q      <= ST_OFF;
      cnt_q        <= '0;
      turbo_q      <= 1'b0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
      thermo_q     <= 4'b0000;
      pwr_prev_q   <= 1'b1;
      mode_prev_q  <= 1'b1;
      turbo_prev_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      turbo_q      <= turbo_d;
      err_q        <= err_d;
      busy_q       <= busy_d;
      thermo_q     <= thermo_d;
      pwr_prev_q   <= Power_Btn_In;
      mode_prev_q  <= Mode_Btn_In;
      turbo_prev_q <= Turbo_Btn_In;
    end
  end

  assign Thermo_Out = thermo_q;
  assign Turbo_Out  = turbo_q;
  assign Busy_Out   = busy_q;
  assign Err_Out    = err_q;

endmodule
